pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised elastic pipeline stage: replaces fixed-struct latches (IF/ID, ID/EX, EX/MEM, MEM/WB)
//  with one generic valid/ready buffer of WIDTH bits and DEPTH entries, plus hold (stall) and flush.
//  Payload is a packed stage struct cast to logic [WIDTH-1:0] by the instantiating datapath.
//  Sits between any two pipeline stages; hazard unit drives hold/flush in place of pStall_t bits.
// PARAMETERS
//  WIDTH  32  payload bits (>=1); set to $bits(<stage struct>)
//  DEPTH  2   entries (1..8); DEPTH=1 is a classic latch (half throughput), >=2 gives full throughput
// PORTS
//  CLK        in   1       clock, rising edge
//  nRST       in   1       asynchronous active-low reset
//  hold       in   1       freeze stage: no push, no pop
//  flush      in   1       discard all entries (branch/jump squash)
//  in_valid   in   1       upstream has data
//  in_ready   out  1       buffer accepts data this cycle
//  in_data    in   WIDTH   upstream payload
//  out_valid  out  1       head entry available
//  out_ready  in   1       downstream consumes head
//  out_data   out  WIDTH   head payload; all-zero when empty (bubble = NOP)
//  count      out  $clog2(DEPTH+1)  occupancy
// BEHAVIOUR
//  - Reset (nRST=0, async): count=0, rd_ptr=wr_ptr=0, out_valid=0, out_data=0; in_ready=!hold.
//    Storage array is not reset; it is unobservable because out_data is masked when empty.
//  - in_ready  = !hold && (count < DEPTH); it does not depend on out_ready (no ready->ready comb path).
//  - out_valid = !hold && (count != 0); out_data = (count!=0) ? mem[rd_ptr] : '0.
//  - push = in_valid && in_ready && !flush; pop = out_valid && out_ready && !flush.
//  - Latency 1 cycle: data pushed at edge N is presented on out_data after edge N.
//  - Push and pop in the same cycle: count unchanged, both pointers advance.
//  - Pointers wrap from DEPTH-1 to 0 (DEPTH need not be a power of two).
//  - Full: in_ready=0, in_data ignored. Empty: out_valid=0, out_ready ignored.
//  - Flush, synchronous: next edge sets count=0 and pointers=0. Flush beats push, pop and hold.
//    in_valid during a flush cycle is dropped; in_ready is not forced low by flush.
//  - Hold without flush: state is frozen and both handshakes are deasserted for that cycle.
//  - nRST asserted mid-transfer aborts everything immediately; no partial entry survives.
//  - Entries hold stable values while buffered; in_data is not re-sampled.
// CONFIGURATION
//  `PIPE_STAGE_PERF_EN defined: adds ports
//     perf_clr     in   1   synchronous clear of both counters
//     stall_cyc    out  32  counts cycles with in_valid && !in_ready
//     bubble_cyc   out  32  counts cycles with out_ready && !out_valid
//   Both counters are saturating at 32'hFFFF_FFFF and reset to 0 by nRST or perf_clr.
//   perf_clr wins over increment. Counters are unaffected by flush.
//  Not defined: these ports and the counters do not exist; datapath behaviour is identical.
// STRUCTURE
//  - pipeline_types_pkg gains:
//     typedef struct packed {logic hold, flush;} pstage_ctrl_t  (per-stage hazard-unit output)
//     localparam PSTAGE_CNT_W = 32
//  - Sub-module pipe_sat_counter (width PSTAGE_CNT_W, inc/clr, saturating) holds the perf counters.
//    It is instantiated twice, only under `PIPE_STAGE_PERF_EN.
//  - Storage is a simple register array mem[DEPTH]; no SRAM macro.
// TESTING
//  1. Reset: nRST=0 mid-stream with count=2 -> count=0, out_valid=0, out_data=0 immediately.
//  2. Streaming, DEPTH=2, out_ready=1, push 0x1..0x8 back-to-back -> 0x1..0x8 in order.
//     One item per cycle after 1-cycle latency; in_ready stays 1.
//  3. Backpressure, out_ready=0, push 0xA,0xB,0xC -> in_ready drops after 2 pushes.
//     0xC is held upstream. Release out_ready -> order 0xA,0xB,0xC with nothing lost.
//  4. Flush with count=2 plus simultaneous in_valid(0xD) -> next cycle count=0, out_valid=0.
//     0xD is not stored.
//  5. Hold=1 for 3 cycles with count=1 and in_valid=1 -> in_ready=0 and out_valid=0 throughout.
//     count stays 1; after hold drops, the head is delivered unchanged.
//  6. DEPTH=3 wrap: 10 push/pop cycles -> pointers wrap 2->0 and data stays in order.
//     With PERF_EN: 4 full-stall cycles -> stall_cyc=4; perf_clr -> stall_cyc=0.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared types and constants for the generic pipeline stage buffer.
package pipe_stage_buf_pkg;

    // Width of the optional performance counters.
    localparam int unsigned PSTAGE_CNT_W = 32;

    // Per-stage hazard-unit output.
    typedef struct packed {
        logic hold;
        logic flush;
    } pstage_ctrl_t;

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with synchronous clear; used for stage perf counters.
module pipe_sat_counter
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned W = PSTAGE_CNT_W
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Clear wins over increment; counting stops at all-ones.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline stage buffer with hold and flush.
// Optional perf counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         hold,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef PIPE_STAGE_PERF_EN
    ,
    input  logic                         perf_clr,
    output logic [PSTAGE_CNT_W-1:0]      stall_cyc,
    output logic [PSTAGE_CNT_W-1:0]      bubble_cyc
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;
    pstage_ctrl_t     ctrl;

    // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign ctrl = '{hold: hold, flush: flush};

    // Handshakes; in_ready never looks at out_ready, and flush does not gate in_ready.
    always_comb begin
        in_ready  = !ctrl.hold && (count < CNT_W'(DEPTH));
        out_valid = !ctrl.hold && (count != '0);
        out_data  = (count != '0) ? mem[rd_ptr] : '0;
        push      = in_valid && in_ready && !ctrl.flush;
        pop       = out_valid && out_ready && !ctrl.flush;
    end

    // Occupancy and pointers; flush overrides everything else.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (ctrl.flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Payload storage; not reset because empty output is masked to zero.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= in_data;
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_counter #(.W(PSTAGE_CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clr   (perf_clr),
        .inc   (in_valid && !in_ready),
        .value (stall_cyc)
    );

    pipe_sat_counter #(.W(PSTAGE_CNT_W)) u_bubble_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clr   (perf_clr),
        .inc   (out_ready && !out_valid),
        .value (bubble_cyc)
    );
`else
    // Performance counters not built; datapath behaviour is unchanged.
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (DEPTH=2 and DEPTH=3 instances).
module tb_pipe_stage_buf;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    // Instance A: WIDTH=32, DEPTH=2
    logic        a_hold, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;
    // Instance B: WIDTH=8, DEPTH=3
    logic        b_hold, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [1:0]  b_count;
`ifdef PIPE_STAGE_PERF_EN
    logic        a_perf_clr, b_perf_clr;
    logic [31:0] a_stall_cyc, a_bubble_cyc, b_stall_cyc, b_bubble_cyc;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) u_dut_a (
        .CLK(CLK), .nRST(nRST), .hold(a_hold), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_clr(a_perf_clr), .stall_cyc(a_stall_cyc), .bubble_cyc(a_bubble_cyc)
`endif
    );

    pipe_stage_buf #(.WIDTH(8), .DEPTH(3)) u_dut_b (
        .CLK(CLK), .nRST(nRST), .hold(b_hold), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_clr(b_perf_clr), .stall_cyc(b_stall_cyc), .bubble_cyc(b_bubble_cyc)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        a_hold = 0; a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        b_hold = 0; b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
`ifdef PIPE_STAGE_PERF_EN
        a_perf_clr = 0; b_perf_clr = 0;
`endif
        #1;
        chk("rst_count",    64'(a_count), 64'd0);
        chk("rst_outvalid", 64'(a_out_valid), 64'd0);
        chk("rst_outdata",  64'(a_out_data), 64'd0);
        chk("rst_inready",  64'(a_in_ready), 64'd1);
        #2 nRST = 1'b1;

        // Streaming 0x1..0x8 through DEPTH=2 with out_ready=1
        a_out_ready = 1; a_in_valid = 1;
        for (int i = 1; i <= 8; i++) begin
            a_in_data = 32'(i);
            tick();
            chk("stream_data",   64'(a_out_data), 64'(i));
            chk("stream_inrdy",  64'(a_in_ready), 64'd1);
            chk("stream_count",  64'(a_count), 64'd1);
        end
        a_in_valid = 0;
        tick();
        chk("stream_empty_cnt",  64'(a_count), 64'd0);
        chk("stream_empty_data", 64'(a_out_data), 64'd0);

        // Backpressure: 0xA,0xB fill, 0xC waits upstream
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'hA;
        tick();
        chk("bp_cnt1", 64'(a_count), 64'd1);
        a_in_data = 32'hB;
        tick();
        chk("bp_cnt2",   64'(a_count), 64'd2);
        chk("bp_full",   64'(a_in_ready), 64'd0);
        a_in_data = 32'hC;
        tick();
        chk("bp_hold_cnt",  64'(a_count), 64'd2);
        chk("bp_head_A",    64'(a_out_data), 64'hA);
        a_out_ready = 1;
        #1;
        chk("bp_no_rdy_path", 64'(a_in_ready), 64'd0);
        tick();
        chk("bp_head_B",  64'(a_out_data), 64'hB);
        chk("bp_rdy_back", 64'(a_in_ready), 64'd1);
        tick();
        chk("bp_head_C",  64'(a_out_data), 64'hC);
        chk("bp_cnt_C",   64'(a_count), 64'd1);
        a_in_valid = 0;
        tick();
        chk("bp_drained", 64'(a_out_valid), 64'd0);

        // Flush with count=2 and a simultaneous 0xD
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h11;
        tick();
        a_in_data = 32'h12;
        tick();
        chk("fl_pre_cnt", 64'(a_count), 64'd2);
        a_flush = 1; a_in_data = 32'hD;
        tick();
        a_flush = 0; a_in_valid = 0;
        chk("fl_cnt",   64'(a_count), 64'd0);
        chk("fl_valid", 64'(a_out_valid), 64'd0);
        chk("fl_data",  64'(a_out_data), 64'd0);
        // Flush with room: in_ready stays high yet the word is dropped
        a_in_valid = 1; a_in_data = 32'h21;
        tick();
        a_flush = 1; a_in_data = 32'h22;
        #1;
        chk("fl_inrdy_high", 64'(a_in_ready), 64'd1);
        tick();
        a_flush = 0; a_in_valid = 0;
        chk("fl_drop_cnt", 64'(a_count), 64'd0);

        // Hold for 3 cycles with count=1 and in_valid=1
        a_in_valid = 1; a_in_data = 32'h55;
        tick();
        a_in_data = 32'h66; a_hold = 1; a_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_inrdy",  64'(a_in_ready), 64'd0);
            chk("hold_outvld", 64'(a_out_valid), 64'd0);
            tick();
            chk("hold_cnt",    64'(a_count), 64'd1);
        end
        a_hold = 0; a_in_valid = 0;
        #1;
        chk("hold_rel_vld",  64'(a_out_valid), 64'd1);
        chk("hold_rel_data", 64'(a_out_data), 64'h55);
        tick();
        chk("hold_rel_cnt",  64'(a_count), 64'd0);

        // Asynchronous reset mid-stream with count=2
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h71;
        tick();
        a_in_data = 32'h72;
        tick();
        chk("ar_pre_cnt", 64'(a_count), 64'd2);
        a_in_valid = 0;
        #2 nRST = 1'b0;
        #1;
        chk("ar_cnt",   64'(a_count), 64'd0);
        chk("ar_vld",   64'(a_out_valid), 64'd0);
        chk("ar_data",  64'(a_out_data), 64'd0);
        #1 nRST = 1'b1;
        tick();
        chk("ar_post_cnt", 64'(a_count), 64'd0);

        // DEPTH=3: fill, stall, drain, then wrap-around streaming
        b_out_ready = 0; b_in_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            b_in_data = 8'(8'hB0 + i);
            tick();
        end
        chk("b_full_cnt", 64'(b_count), 64'd3);
        chk("b_full_rdy", 64'(b_in_ready), 64'd0);
        b_in_data = 8'hB4;
        for (int i = 0; i < 4; i++) tick();
        chk("b_stall_cnt",  64'(b_count), 64'd3);
        chk("b_stall_head", 64'(b_out_data), 64'hB1);
`ifdef PIPE_STAGE_PERF_EN
        chk("b_stall_cyc", 64'(b_stall_cyc), 64'd4);
        b_perf_clr = 1;
        tick();
        b_perf_clr = 0;
        chk("b_stall_clr", 64'(b_stall_cyc), 64'd0);
`endif
        b_in_valid = 0; b_out_ready = 1;
        #1;
        chk("b_drain_1", 64'(b_out_data), 64'hB1);
        tick();
        chk("b_drain_2", 64'(b_out_data), 64'hB2);
        tick();
        chk("b_drain_3", 64'(b_out_data), 64'hB3);
        tick();
        chk("b_drain_empty", 64'(b_out_valid), 64'd0);
        b_in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            b_in_data = 8'(8'hC0 + i);
            tick();
            chk("b_wrap_data", 64'(b_out_data), 64'(8'hC0 + i));
        end
        b_in_valid = 0;
        tick();
        chk("b_wrap_end", 64'(b_count), 64'd0);
        tick();
        tick();
`ifdef PIPE_STAGE_PERF_EN
        chk("b_bubble_cyc", 64'(b_bubble_cyc), 64'd3);
        chk("b_stall_end",  64'(b_stall_cyc), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
